// File: rtl/issue_pkg.sv
// Shared widths, execution-unit encodings and issue FSM states.
package issue_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned UNIT_W = 3;
  localparam int unsigned NREG   = 32;

  localparam logic [UNIT_W-1:0] EX_ALU = 3'd0;
  localparam logic [UNIT_W-1:0] EX_FWD = 3'd1;
  localparam logic [UNIT_W-1:0] EX_JMP = 3'd2;

  typedef enum logic {
    RUN      = 1'b0,
    WAIT_JMP = 1'b1
  } state_e;
endpackage

// File: rtl/issue_unit_scoreboard.sv
// Register busy tracking; reports busy sources/destination net of a same-cycle writeback.
module scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs1_idx,
  input  logic [4:0] rs2_idx,
  input  logic [4:0] rd_idx,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_busy
);
  import issue_pkg::*;

  logic [NREG-1:0] busy_q, busy_d;

  // A register being written back this cycle no longer blocks.
  function automatic logic blocked(input logic [NREG-1:0] busy, input logic [4:0] idx,
                                   input logic cen, input logic [4:0] cidx);
    return (idx != 5'd0) && busy[idx] && !(cen && (cidx == idx));
  endfunction

  assign rs1_busy = blocked(busy_q, rs1_idx, clr_en, clr_idx);
  assign rs2_busy = blocked(busy_q, rs2_idx, clr_en, clr_idx);
  assign rd_busy  = blocked(busy_q, rd_idx,  clr_en, clr_idx);

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
endmodule

// File: rtl/issue_unit.sv
// Issue stage: hazard check, operand gather with writeback bypass, registered issue slot.
module issue_unit #(
  parameter int unsigned XLEN   = issue_pkg::XLEN,
  parameter int unsigned OP_W   = issue_pkg::OP_W,
  parameter int unsigned UNIT_W = issue_pkg::UNIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_op,
  input  logic [UNIT_W-1:0] dec_ex_unit,
  input  logic              dec_rs1_en,
  input  logic              dec_rs2_en,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_rd_en,
  input  logic [4:0]        dec_rd,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic              dec_imm_en,
  input  logic              dec_pc_en,
  input  logic              dec_stall,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              jmp_done,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [UNIT_W-1:0] ex_unit,
  output logic [XLEN-1:0]   ex_src1,
  output logic [XLEN-1:0]   ex_src2,
  output logic              ex_rd_en,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc
);
  import issue_pkg::*;

  state_e            state_q, state_d;
  logic              rs1_busy, rs2_busy, rd_busy;
  logic              hazard, fire;
  logic [XLEN-1:0]   rs1_val, rs2_val, src1_d, src2_d;
  logic              ex_valid_q, ex_rd_en_q;
  logic [OP_W-1:0]   ex_op_q;
  logic [UNIT_W-1:0] ex_unit_q;
  logic [4:0]        ex_rd_q;
  logic [XLEN-1:0]   ex_src1_q, ex_src2_q, ex_imm_q, ex_pc_q;

  scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (fire && dec_rd_en && (dec_rd != 5'd0)),
    .set_idx  (dec_rd),
    .clr_en   (wb_en),
    .clr_idx  (wb_rd),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rd_idx   (dec_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  assign hazard    = (dec_rs1_en && rs1_busy) || (dec_rs2_en && rs2_busy) || (dec_rd_en && rd_busy);
  assign dec_ready = !rst && (state_q == RUN) && (!ex_valid_q || ex_ready) && !hazard;
  assign fire      = dec_valid && dec_ready;

  assign rs1_val = (wb_en && (wb_rd == dec_rs1) && (dec_rs1 != 5'd0)) ? wb_data : rf_rs1_data;
  assign rs2_val = (wb_en && (wb_rd == dec_rs2) && (dec_rs2 != 5'd0)) ? wb_data : rf_rs2_data;
  assign src1_d  = dec_pc_en  ? dec_pc  : dec_rs1_en ? rs1_val : '0;
  assign src2_d  = dec_imm_en ? dec_imm : dec_rs2_en ? rs2_val : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (fire && dec_stall) state_d = WAIT_JMP;
      WAIT_JMP: if (jmp_done)          state_d = RUN;
      default:                         state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_unit_q  <= '0;
      ex_src1_q  <= '0;
      ex_src2_q  <= '0;
      ex_rd_en_q <= 1'b0;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
    end else if (fire) begin
      ex_valid_q <= 1'b1;
      ex_op_q    <= dec_op;
      ex_unit_q  <= dec_ex_unit;
      ex_src1_q  <= src1_d;
      ex_src2_q  <= src2_d;
      ex_rd_en_q <= dec_rd_en;
      ex_rd_q    <= dec_rd;
      ex_imm_q   <= dec_imm;
      ex_pc_q    <= dec_pc;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_unit  = ex_unit_q;
  assign ex_src1  = ex_src1_q;
  assign ex_src2  = ex_src2_q;
  assign ex_rd_en = ex_rd_en_q;
  assign ex_rd    = ex_rd_q;
  assign ex_imm   = ex_imm_q;
  assign ex_pc    = ex_pc_q;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit with hand-computed expectations.
module tb_issue_unit;
  import issue_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_valid, dec_ready;
  logic [OP_W-1:0]   dec_op;
  logic [UNIT_W-1:0] dec_ex_unit;
  logic              dec_rs1_en, dec_rs2_en, dec_rd_en;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]   dec_imm, dec_pc;
  logic              dec_imm_en, dec_pc_en, dec_stall;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              jmp_done;
  logic              ex_valid, ex_ready, ex_rd_en;
  logic [OP_W-1:0]   ex_op;
  logic [UNIT_W-1:0] ex_unit;
  logic [XLEN-1:0]   ex_src1, ex_src2, ex_imm, ex_pc;
  logic [4:0]        ex_rd;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  // Register file model: xN reads as 0x1000+N, x0 reads as 0.
  assign rf_rs1_data = (dec_rs1 == 5'd0) ? '0 : 32'h1000 + {27'd0, dec_rs1};
  assign rf_rs2_data = (dec_rs2 == 5'd0) ? '0 : 32'h1000 + {27'd0, dec_rs2};

  issue_unit #(.XLEN(32), .OP_W(4), .UNIT_W(3)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_ex_unit(dec_ex_unit),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd_en(dec_rd_en), .dec_rd(dec_rd), .dec_imm(dec_imm), .dec_imm_en(dec_imm_en),
    .dec_pc_en(dec_pc_en), .dec_stall(dec_stall), .dec_pc(dec_pc),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .jmp_done(jmp_done),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_unit(ex_unit),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_rd_en(ex_rd_en), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_instr(input logic rs1_en, input logic [4:0] rs1,
                           input logic rs2_en, input logic [4:0] rs2,
                           input logic rd_en, input logic [4:0] rd,
                           input logic [31:0] imm, input logic imm_en,
                           input logic pc_en, input logic stall);
    dec_rs1_en = rs1_en; dec_rs1 = rs1;
    dec_rs2_en = rs2_en; dec_rs2 = rs2;
    dec_rd_en  = rd_en;  dec_rd  = rd;
    dec_imm    = imm;    dec_imm_en = imm_en;
    dec_pc_en  = pc_en;  dec_stall  = stall;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_en = en; wb_rd = rd; wb_data = data;
  endtask

  initial begin
    rst = 1'b1; ex_ready = 1'b1; jmp_done = 1'b0;
    dec_op = 4'h1; dec_ex_unit = EX_ALU; dec_pc = 32'h100;
    set_wb(1'b0, 5'd0, '0);
    // Reset held with a valid instruction pending
    dec_valid = 1'b1;
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'd5, 1'b1, 1'b0, 1'b0);
    settle();
    check("rst_dec_ready", {31'd0, dec_ready}, 32'd0);
    tick(); tick();
    settle();
    check("rst_dec_ready2", {31'd0, dec_ready}, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_src2", ex_src2, 32'd0);
    check("rst_busy", dut.u_sb.busy_q, 32'd0);
    rst = 1'b0; dec_valid = 1'b0;
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("idle_dec_ready", {31'd0, dec_ready}, 32'd1);

    // Back-to-back: addi x1,x0,5 ; addi x2,x0,7
    dec_valid = 1'b1;
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'd5, 1'b1, 1'b0, 1'b0);
    settle();
    check("b2b_ready1", {31'd0, dec_ready}, 32'd1);
    tick();
    check("b2b_valid1", {31'd0, ex_valid}, 32'd1);
    check("b2b_src2_1", ex_src2, 32'd5);
    check("b2b_rd1", {27'd0, ex_rd}, 32'd1);
    check("b2b_src1_1", ex_src1, 32'd0);
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'd7, 1'b1, 1'b0, 1'b0);
    settle();
    check("b2b_ready2", {31'd0, dec_ready}, 32'd1);
    tick();
    check("b2b_valid2", {31'd0, ex_valid}, 32'd1);
    check("b2b_src2_2", ex_src2, 32'd7);
    check("b2b_rd2", {27'd0, ex_rd}, 32'd2);
    check("b2b_busy", dut.u_sb.busy_q, 32'h6);

    // Retire x2, then add x3,x1,x2 waits on x1
    dec_valid = 1'b0;
    set_wb(1'b1, 5'd2, 32'h77);
    tick();
    check("wb2_busy", dut.u_sb.busy_q, 32'h2);
    check("drain_valid", {31'd0, ex_valid}, 32'd0);
    set_wb(1'b0, 5'd0, '0);
    dec_valid = 1'b1; dec_op = 4'h2;
    set_instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("raw_stall", {31'd0, dec_ready}, 32'd0);
    tick();
    check("raw_no_issue", {31'd0, ex_valid}, 32'd0);
    set_wb(1'b1, 5'd1, 32'h55);
    settle();
    check("raw_bypass_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    set_wb(1'b0, 5'd0, '0);
    check("raw_src1", ex_src1, 32'h55);
    check("raw_src2", ex_src2, 32'h1002);
    check("raw_rd", {27'd0, ex_rd}, 32'd3);
    check("raw_busy", dut.u_sb.busy_q, 32'h8);

    // Backpressure with add x3 in the slot
    ex_ready = 1'b0; dec_op = 4'h1;
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'd9, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      settle();
      check("bp_ready", {31'd0, dec_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, ex_valid}, 32'd1);
      check("bp_rd", {27'd0, ex_rd}, 32'd3);
      check("bp_src1", ex_src1, 32'h55);
      check("bp_op", {28'd0, ex_op}, 32'h2);
    end
    ex_ready = 1'b1;
    settle();
    check("bp_release_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    check("bp_next_rd", {27'd0, ex_rd}, 32'd4);
    check("bp_next_src2", ex_src2, 32'd9);
    check("bp_busy", dut.u_sb.busy_q, 32'h18);

    // WAW on x3 stalls until its writeback, then same-cycle set wins
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd1, 1'b1, 1'b0, 1'b0);
    settle();
    check("waw_stall", {31'd0, dec_ready}, 32'd0);
    set_wb(1'b1, 5'd3, 32'h33);
    settle();
    check("waw_wb_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    set_wb(1'b0, 5'd0, '0);
    check("waw_set_wins", dut.u_sb.busy_q, 32'h18);

    // rd=x0 never marks busy
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check("x0_rd_valid", {31'd0, ex_valid}, 32'd1);
    check("x0_busy", dut.u_sb.busy_q, 32'h18);

    // jal x1 stalls the front end until jmp_done
    dec_ex_unit = EX_JMP; dec_op = 4'h8; dec_pc = 32'h200;
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'd4, 1'b1, 1'b1, 1'b1);
    settle();
    check("jal_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    check("jal_state", {31'd0, dut.state_q}, {31'd0, WAIT_JMP});
    check("jal_src1", ex_src1, 32'h200);
    check("jal_pc", ex_pc, 32'h200);
    check("jal_unit", {29'd0, ex_unit}, {29'd0, EX_JMP});
    dec_ex_unit = EX_ALU; dec_op = 4'h1;
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      settle();
      check("jwait_ready", {31'd0, dec_ready}, 32'd0);
      tick();
    end
    jmp_done = 1'b1;
    settle();
    check("jdone_ready_same", {31'd0, dec_ready}, 32'd0);
    tick();
    jmp_done = 1'b0;
    settle();
    check("jdone_ready_next", {31'd0, dec_ready}, 32'd1);
    check("jdone_busy1", dut.u_sb.busy_q, 32'h1A);

    // jmp_done while running is ignored
    dec_valid = 1'b0; jmp_done = 1'b1;
    tick();
    jmp_done = 1'b0;
    check("jdone_run_state", {31'd0, dut.state_q}, {31'd0, RUN});

    // Reset during WAIT_JMP
    dec_valid = 1'b1; dec_ex_unit = EX_JMP;
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'd4, 1'b1, 1'b1, 1'b1);
    tick();
    check("jal2_state", {31'd0, dut.state_q}, {31'd0, WAIT_JMP});
    check("jal2_busy", dut.u_sb.busy_q, 32'h3A);
    dec_valid = 1'b0; rst = 1'b1;
    settle();
    check("rst_mid_ready", {31'd0, dec_ready}, 32'd0);
    tick();
    rst = 1'b0;
    check("rst_mid_state", {31'd0, dut.state_q}, {31'd0, RUN});
    check("rst_mid_busy", dut.u_sb.busy_q, 32'd0);
    check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_mid_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_mid_pc", ex_pc, 32'd0);
    settle();
    check("rst_mid_ready_after", {31'd0, dec_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
